coeff_threshold_stream: RTL and testbench

//  Streaming, block-aware threshold stage between the DCT output and the RLE encoder.

---
 rtl/coeff_threshold_stream_if.sv | 29 ++
 rtl/coeff_threshold_stream.sv | 119 +++++++++++
 tb/tb_coeff_threshold_stream.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coeff_threshold_stream_if.sv
// Stream bundle for the coefficient threshold stage: input beat, output beat,
// block framing/zero-count sideband and the per-block threshold controls.
interface coeff_threshold_stream_if #(
  parameter int WIDTH     = 13,
  parameter int BLOCK_LEN = 64,
  parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
);
  logic                 mode_soft;
  logic [WIDTH-2:0]     thr_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic                 out_last;
  logic [CNT_W-1:0]     zero_count;
  logic                 zero_count_valid;

  modport master (
    output mode_soft, thr_in, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, zero_count, zero_count_valid
  );

  modport slave (
    input  mode_soft, thr_in, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, zero_count, zero_count_valid
  );
endinterface

// File: rtl/coeff_threshold_stream.sv
// Block-aware hard/soft threshold stage between the DCT and the RLE encoder;
// one output register, per-block latched threshold and per-block zero count.
module coeff_threshold_stream #(
  parameter int WIDTH     = 13,
  parameter int BLOCK_LEN = 64,
  parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
  input logic                     clk,
  input logic                     rst,
  coeff_threshold_stream_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);
  localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] idx_r;
  logic [CNT_W-1:0] run_zero_r;
  logic [WIDTH-2:0] thr_r;
  logic             mode_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_last_r;
  logic [CNT_W-1:0] zero_count_r;
  logic             zero_count_valid_r;

  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-2:0] thr_s;
  logic             mode_s;
  logic [WIDTH-1:0] mag_s;
  logic             small_s;
  logic [WIDTH:0]   x_ext_s;
  logic [WIDTH:0]   t_ext_s;
  logic [WIDTH:0]   soft_s;
  logic [WIDTH-1:0] y_s;
  logic             y_zero_s;
  logic             is_last_s;

  assign in_ready_s = !out_valid_r || bus.out_ready;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign is_last_s  = (idx_r == LAST_IDX);

  // Threshold datapath; index 0 uses the live controls, the rest of the block the latched ones.
  always_comb begin
    thr_s  = thr_r;
    mode_s = mode_r;
    if (idx_r == ZERO_C) begin
      thr_s  = bus.thr_in;
      mode_s = bus.mode_soft;
    end else begin
      thr_s  = thr_r;
      mode_s = mode_r;
    end
    // Magnitude kept unsigned so that the most negative value maps to 2^(WIDTH-1).
    mag_s   = bus.in_data[WIDTH-1] ? (~bus.in_data + ONE_W) : bus.in_data;
    small_s = (mag_s <= {1'b0, thr_s});
    x_ext_s = {bus.in_data[WIDTH-1], bus.in_data};
    t_ext_s = {2'b00, thr_s};
    if (bus.in_data[WIDTH-1]) begin
      soft_s = x_ext_s + t_ext_s;
    end else begin
      soft_s = x_ext_s - t_ext_s;
    end
    if (small_s) begin
      y_s = ZERO_W;
    end else if (mode_s) begin
      y_s = soft_s[WIDTH-1:0];
    end else begin
      y_s = bus.in_data;
    end
    y_zero_s = (y_s == ZERO_W);
  end

  // Output register, block framing, latched controls and zero counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r              <= ZERO_C;
      run_zero_r         <= ZERO_C;
      thr_r              <= {(WIDTH-1){1'b0}};
      mode_r             <= 1'b0;
      out_valid_r        <= 1'b0;
      out_data_r         <= ZERO_W;
      out_last_r         <= 1'b0;
      zero_count_r       <= ZERO_C;
      zero_count_valid_r <= 1'b0;
    end else if (accept_s) begin
      out_valid_r        <= 1'b1;
      out_data_r         <= y_s;
      out_last_r         <= is_last_s;
      zero_count_valid_r <= is_last_s;
      if (idx_r == ZERO_C) begin
        thr_r  <= bus.thr_in;
        mode_r <= bus.mode_soft;
      end
      if (is_last_s) begin
        idx_r        <= ZERO_C;
        run_zero_r   <= ZERO_C;
        zero_count_r <= run_zero_r + (y_zero_s ? ONE_C : ZERO_C);
      end else begin
        idx_r      <= idx_r + ONE_C;
        run_zero_r <= run_zero_r + (y_zero_s ? ONE_C : ZERO_C);
      end
    end else if (bus.out_ready) begin
      out_valid_r        <= 1'b0;
      zero_count_valid_r <= 1'b0;
    end
  end

  assign bus.in_ready         = in_ready_s;
  assign bus.out_valid        = out_valid_r;
  assign bus.out_data         = out_data_r;
  assign bus.out_last         = out_last_r;
  assign bus.zero_count       = zero_count_r;
  assign bus.zero_count_valid = zero_count_valid_r;

endmodule

// File: tb/tb_coeff_threshold_stream.sv
// Directed self-checking bench for coeff_threshold_stream (WIDTH=13, BLOCK_LEN=8).
module tb_coeff_threshold_stream;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  coeff_threshold_stream_if #(.WIDTH(13), .BLOCK_LEN(8)) bus ();

  coeff_threshold_stream #(.WIDTH(13), .BLOCK_LEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one beat; returns 1 time unit after the accepting edge.
  task automatic beat(input int x);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 13'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 13'd0 || bus.out_last !== 1'b0 ||
        bus.zero_count !== 4'd0 || bus.zero_count_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%0d last=%b zc=%0d zcv=%b rdy=%b, required 0 0 0 0 0 1",
               bus.out_valid, bus.out_data, bus.out_last, bus.zero_count, bus.zero_count_valid, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: valid=%b rdy=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_hard();
    int vin[6]  = '{-3, -4, 3, 4, 0, -4096};
    int vexp[6] = '{0, -4, 0, 4, 0, -4096};
    do_reset();
    bus.mode_soft = 1'b0;
    bus.thr_in    = 12'd3;
    for (int i = 0; i < 6; i++) begin
      beat(vin[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 13'(vexp[i]) || bus.out_last !== 1'b0) begin
        errors++;
        $display("FAIL hard_%0d: valid=%b data=%0d last=%b, required 1 %0d 0",
                 i, bus.out_valid, $signed(bus.out_data), bus.out_last, vexp[i]);
      end
    end
    idle();
  endtask

  task automatic test_soft();
    int vin[5]  = '{-4, 10, 3, -4096, 4095};
    int vexp[5] = '{-1, 7, 0, -4093, 4092};
    do_reset();
    bus.mode_soft = 1'b1;
    bus.thr_in    = 12'd3;
    for (int i = 0; i < 5; i++) begin
      beat(vin[i]);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 13'(vexp[i])) begin
        errors++;
        $display("FAIL soft_%0d: valid=%b data=%0d, required 1 %0d",
                 i, bus.out_valid, $signed(bus.out_data), vexp[i]);
      end
    end
    idle();
  endtask

  task automatic test_boundary();
    // hard T=0 is identity; soft T=4095 zeroes all but the most negative value
    int vin[4]  = '{5, -1, 4095, -4096};
    int vexp[4] = '{5, -1, 4095, -4096};
    int sin[3]  = '{-4096, 4095, -1};
    int sexp[3] = '{-1, 0, 0};
    do_reset();
    bus.mode_soft = 1'b0;
    bus.thr_in    = 12'd0;
    for (int i = 0; i < 4; i++) begin
      beat(vin[i]);
      checks++;
      if (bus.out_data !== 13'(vexp[i])) begin
        errors++;
        $display("FAIL t0_identity_%0d: data=%0d, required %0d", i, $signed(bus.out_data), vexp[i]);
      end
    end
    do_reset();
    bus.mode_soft = 1'b1;
    bus.thr_in    = 12'd4095;
    for (int i = 0; i < 3; i++) begin
      beat(sin[i]);
      checks++;
      if (bus.out_data !== 13'(sexp[i])) begin
        errors++;
        $display("FAIL tmax_soft_%0d: data=%0d, required %0d", i, $signed(bus.out_data), sexp[i]);
      end
    end
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mode_soft = 1'b0;
    bus.thr_in    = 12'd0;
    beat(100);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_data   = 13'd200;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd100 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: valid=%b data=%0d rdy=%b, required 1 100 0",
                 i, bus.out_valid, bus.out_data, bus.in_ready);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 13'd200) begin
      errors++;
      $display("FAIL stall_release: valid=%b data=%0d, required 1 200", bus.out_valid, bus.out_data);
    end
    idle();
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_block();
    int vin[8]  = '{0, 1, 5, -2, -7, 2, 0, 9};
    int vexp[8] = '{0, 0, 5, 0, -7, 0, 0, 9};
    do_reset();
    bus.mode_soft = 1'b0;
    bus.thr_in    = 12'd2;
    for (int i = 0; i < 8; i++) begin
      beat(vin[i]);
      checks++;
      if (bus.out_data !== 13'(vexp[i]) || bus.out_last !== (i == 7) ||
          bus.zero_count_valid !== (i == 7)) begin
        errors++;
        $display("FAIL block_%0d: data=%0d last=%b zcv=%b, required %0d %0d %0d",
                 i, $signed(bus.out_data), bus.out_last, bus.zero_count_valid, vexp[i], (i == 7), (i == 7));
      end
    end
    checks++;
    if (bus.zero_count !== 4'd5) begin
      errors++;
      $display("FAIL block_zero_count: zc=%0d, required 5", bus.zero_count);
    end
    idle();
    @(posedge clk);
    #1;
    checks++;
    if (bus.zero_count_valid !== 1'b0 || bus.zero_count !== 4'd5 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL block_after: zcv=%b zc=%0d valid=%b, required 0 5 0",
               bus.zero_count_valid, bus.zero_count, bus.out_valid);
    end
  endtask

  task automatic test_thr_latch();
    do_reset();
    bus.mode_soft = 1'b0;
    bus.thr_in    = 12'd2;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.thr_in = 12'd10;
      beat(5);
      checks++;
      if (bus.out_data !== ((i < 8) ? 13'd5 : 13'd0)) begin
        errors++;
        $display("FAIL thr_latch_%0d: data=%0d, required %0d", i, bus.out_data, (i < 8) ? 5 : 0);
      end
      if (i == 7) begin
        checks++;
        if (bus.zero_count !== 4'd0 || bus.out_last !== 1'b1) begin
          errors++;
          $display("FAIL thr_latch_zc: zc=%0d last=%b, required 0 1", bus.zero_count, bus.out_last);
        end
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    do_reset();
    bus.mode_soft = 1'b0;
    bus.thr_in    = 12'd0;
    for (int i = 0; i < 5; i++) beat(0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst          = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 13'd0 || bus.out_last !== 1'b0 ||
        bus.zero_count !== 4'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: valid=%b data=%0d last=%b zc=%0d rdy=%b, required 0 0 0 0 1",
               bus.out_valid, bus.out_data, bus.out_last, bus.zero_count, bus.in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      beat((i % 2 == 0) ? 0 : 7);
      checks++;
      if (bus.out_last !== (i == 7) || bus.out_data !== ((i % 2 == 0) ? 13'd0 : 13'd7)) begin
        errors++;
        $display("FAIL fresh_block_%0d: last=%b data=%0d, required %0d %0d",
                 i, bus.out_last, bus.out_data, (i == 7), (i % 2 == 0) ? 0 : 7);
      end
    end
    checks++;
    if (bus.zero_count !== 4'd4) begin
      errors++;
      $display("FAIL fresh_zero_count: zc=%0d, required 4", bus.zero_count);
    end
    idle();
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    bus.mode_soft = 1'b0;
    bus.thr_in    = 12'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 13'd0;
    bus.out_ready = 1'b1;
    test_reset();
    test_hard();
    test_soft();
    test_boundary();
    test_backpressure();
    test_block();
    test_thr_latch();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
